// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite register front-end for the custom_axi_ip core: operand/start control,
// registered core results, sticky DONE/ERR flags and a level interrupt.
module custom_axi_ip_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [15:0]             hw_din_o,
  output logic                    hw_enable_o,
  input  logic [15:0]             hw_dout_i,
  input  logic [1:0]              hw_enable_i,
  input  logic [1:0]              hw_status_i,
  output logic                    irq_o
);

  localparam logic [1:0] SEL_CTRL   = 2'd0;
  localparam logic [1:0] SEL_DIN    = 2'd1;
  localparam logic [1:0] SEL_DOUT   = 2'd2;
  localparam logic [1:0] SEL_STATUS = 2'd3;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [1:0] ST_ERROR   = 2'd3;

  logic                  aw_held, w_held;
  logic [1:0]            aw_sel;
  logic [15:0]           w_data;
  logic [1:0]            w_strb;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q;
  logic [DATA_WIDTH-1:0] rdata_q, rd_word;
  logic                  ie, done, err, hw_enable_q, irq_q;
  logic [15:0]           din, dout_q;
  logic [1:0]            status_q, enable_q;
  logic                  aw_hs, w_hs, ar_hs, do_write;
  logic                  start_cmd, done_set, done_clr, err_set, err_clr;
  logic                  unused_bits;

  // Handshake: a beat transfers on a rising clk_i edge where valid && ready.
  // Masters hold valid and payload stable until ready; responses (bvalid/rvalid)
  // hold their payload until the matching bready/rready completes the beat.
  assign s_axi_awready = !rst_i && !aw_held && !bvalid_q;
  assign s_axi_wready  = !rst_i && !w_held && !bvalid_q;
  assign s_axi_arready = !rst_i && !rvalid_q;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // Both halves buffered: this is the single cycle in which registers update.
  assign do_write  = aw_held && w_held;
  assign start_cmd = do_write && (aw_sel == SEL_CTRL) && w_strb[0] && w_data[0];
  assign done_clr  = do_write && (aw_sel == SEL_STATUS) && w_strb[0] && w_data[4];
  assign err_clr   = do_write && (aw_sel == SEL_STATUS) && w_strb[0] && w_data[5];
  assign done_set  = (hw_status_i == ST_DONE) && (status_q != ST_DONE);
  assign err_set   = ((hw_status_i == ST_ERROR) && (status_q != ST_ERROR)) ||
                     (start_cmd && (status_q != ST_IDLE));

  assign s_axi_bvalid = bvalid_q;
  assign s_axi_bresp  = bresp_q;
  assign s_axi_rvalid = rvalid_q;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = 2'b00;
  assign hw_din_o     = din;
  assign hw_enable_o  = hw_enable_q;
  assign irq_o        = irq_q;

  assign unused_bits = &{1'b0, s_axi_wdata[DATA_WIDTH-1:16], s_axi_wstrb[DATA_WIDTH/8-1:2],
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_held  <= 1'b0;
      aw_sel   <= '0;
      w_held   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_sel  <= s_axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata[15:0];
        w_strb <= s_axi_wstrb[1:0];
      end
      if (do_write) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= (aw_sel == SEL_DOUT) ? 2'b10 : 2'b00;
      end else if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ie          <= 1'b0;
      din         <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      hw_enable_q <= 1'b0;
      irq_q       <= 1'b0;
      dout_q      <= '0;
      status_q    <= '0;
      enable_q    <= '0;
    end else begin
      if (do_write && (aw_sel == SEL_CTRL) && w_strb[0]) ie <= w_data[1];
      if (do_write && (aw_sel == SEL_DIN)) begin
        if (w_strb[0]) din[7:0]  <= w_data[7:0];
        if (w_strb[1]) din[15:8] <= w_data[15:8];
      end
      // A set in the same cycle as a write-one-to-clear wins.
      done        <= done_set || (done && !done_clr);
      err         <= err_set || (err && !err_clr);
      hw_enable_q <= start_cmd;
      irq_q       <= done && ie;
      dout_q      <= hw_dout_i;
      status_q    <= hw_status_i;
      enable_q    <= hw_enable_i;
    end
  end

  always_comb begin
    rd_word = '0;
    case (s_axi_araddr[3:2])
      SEL_CTRL: rd_word[1]    = ie;
      SEL_DIN:  rd_word[15:0] = din;
      SEL_DOUT: rd_word[15:0] = dout_q;
      default:  rd_word[5:0]  = {err, done, enable_q, status_q};
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_word;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule
